// File: rtl/backplane_bus_fabric.sv
// Backplane bus fabric: explicit slot-driver resolver with optional keeper,
// contention capture, and a synchronised, latched interrupt front end.

module backplane_bus_fabric_irq_chan (
   input  logic clk,
   input  logic rst,
   input  logic irq_in,
   input  logic irq_ack,
   output logic pend
);
   // sync_q[0]/[1] form the synchroniser, sync_q[2] delays s2 for edge detection
   logic [2:0] sync_q, sync_d;
   logic       pend_q, pend_d;

   always_comb begin
      sync_d = {sync_q[1:0], irq_in};
      pend_d = (pend_q & ~irq_ack) | (sync_q[1] & ~sync_q[2]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         pend_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         pend_q <= pend_d;
      end
   end

   assign pend = pend_q;
endmodule

module backplane_bus_fabric #(
   parameter int DW      = 26,
   parameter int NSLOTS  = 5,
   parameter int RESOLVE = 1,
   parameter int KEEPER  = 0,
   parameter int CW      = 8,
   parameter int NIRQ    = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NSLOTS-1:0]    DRV_EN,
   input  logic [NSLOTS*DW-1:0] DRV_DATA,
   output logic [DW-1:0]        DB,
   output logic                 BUS_IDLE,
   output logic                 CONTENTION,
   output logic                 CONT_STICKY,
   output logic [NSLOTS-1:0]    CONT_MASK,
   output logic [CW-1:0]        CONT_CNT,
   input  logic                 CLR_STATUS,
   input  logic [NIRQ-1:0]      IRQ_IN,
   input  logic [NIRQ-1:0]      IRQ_MASK,
   input  logic [NIRQ-1:0]      IRQ_ACK,
   output logic [NIRQ-1:0]      IRQ_PEND,
   output logic                 INT_OUT
);
   logic [DW-1:0]     res;
   logic              found;
   logic [DW-1:0]     keeper_q;
   logic              sticky_q, sticky_d;
   logic [NSLOTS-1:0] mask_q, mask_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   always_comb begin
      res   = '0;
      found = 1'b0;
      for (int i = 0; i < NSLOTS; i++) begin
         if (DRV_EN[i]) begin
            if (RESOLVE == 0) begin
               res = res | DRV_DATA[i*DW +: DW];
            end else if (!found) begin
               res   = DRV_DATA[i*DW +: DW];
               found = 1'b1;
            end
         end
      end
   end

   assign BUS_IDLE   = (DRV_EN == '0);
   // clearing the lowest set bit leaves something only if two or more are set
   assign CONTENTION = ((DRV_EN & (DRV_EN - NSLOTS'(1))) != '0);
   assign DB         = BUS_IDLE ? keeper_q : res;

   generate
      if (KEEPER != 0) begin : g_keeper
         logic [DW-1:0] keeper_d;
         always_comb keeper_d = BUS_IDLE ? keeper_q : res;
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) keeper_q <= '0;
            else     keeper_q <= keeper_d;
         end
      end else begin : g_no_keeper
         assign keeper_q = '0;
      end
   endgenerate

   // clear is applied first so a same-edge contention re-captures from scratch
   always_comb begin
      sticky_d = sticky_q & ~CLR_STATUS;
      mask_d   = CLR_STATUS ? '0 : mask_q;
      cnt_d    = CLR_STATUS ? '0 : cnt_q;
      if (CONTENTION) begin
         if (!sticky_d) mask_d = DRV_EN;
         sticky_d = 1'b1;
         if (cnt_d != '1) cnt_d = cnt_d + CW'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sticky_q <= 1'b0;
         mask_q   <= '0;
         cnt_q    <= '0;
      end else begin
         sticky_q <= sticky_d;
         mask_q   <= mask_d;
         cnt_q    <= cnt_d;
      end
   end

   assign CONT_STICKY = sticky_q;
   assign CONT_MASK   = mask_q;
   assign CONT_CNT    = cnt_q;

   generate
      for (genvar g = 0; g < NIRQ; g++) begin : g_irq
         backplane_bus_fabric_irq_chan u_chan (
            .clk     (CLK),
            .rst     (RST),
            .irq_in  (IRQ_IN[g]),
            .irq_ack (IRQ_ACK[g]),
            .pend    (IRQ_PEND[g])
         );
      end
   endgenerate

   assign INT_OUT = |(IRQ_PEND & IRQ_MASK);
endmodule

// File: tb/tb_backplane_bus_fabric.sv
// Scoreboard bench: two fabric instances (priority/no keeper and wired-OR/keeper/CW=2)
// driven by directed then random traffic, checked against a queue-based reference.

module tb_backplane_bus_fabric;
   localparam int DW = 26;
   localparam int NS = 5;
   localparam int NI = 4;

   logic              CLK, RST;
   logic [NS-1:0]     DRV_EN;
   logic [NS*DW-1:0]  DRV_DATA;
   logic              CLR_STATUS;
   logic [NI-1:0]     IRQ_IN, IRQ_MASK, IRQ_ACK;

   logic [DW-1:0] a_db, b_db;
   logic          a_idle, b_idle, a_cont, b_cont, a_st, b_st, a_int, b_int;
   logic [NS-1:0] a_mk, b_mk;
   logic [7:0]    a_cnt;
   logic [1:0]    b_cnt;
   logic [NI-1:0] a_pend, b_pend;

   backplane_bus_fabric #(.DW(DW), .NSLOTS(NS), .RESOLVE(1), .KEEPER(0), .CW(8), .NIRQ(NI)) dut_a (
      .CLK(CLK), .RST(RST), .DRV_EN(DRV_EN), .DRV_DATA(DRV_DATA), .DB(a_db),
      .BUS_IDLE(a_idle), .CONTENTION(a_cont), .CONT_STICKY(a_st), .CONT_MASK(a_mk),
      .CONT_CNT(a_cnt), .CLR_STATUS(CLR_STATUS), .IRQ_IN(IRQ_IN), .IRQ_MASK(IRQ_MASK),
      .IRQ_ACK(IRQ_ACK), .IRQ_PEND(a_pend), .INT_OUT(a_int));

   backplane_bus_fabric #(.DW(DW), .NSLOTS(NS), .RESOLVE(0), .KEEPER(1), .CW(2), .NIRQ(NI)) dut_b (
      .CLK(CLK), .RST(RST), .DRV_EN(DRV_EN), .DRV_DATA(DRV_DATA), .DB(b_db),
      .BUS_IDLE(b_idle), .CONTENTION(b_cont), .CONT_STICKY(b_st), .CONT_MASK(b_mk),
      .CONT_CNT(b_cnt), .CLR_STATUS(CLR_STATUS), .IRQ_IN(IRQ_IN), .IRQ_MASK(IRQ_MASK),
      .IRQ_ACK(IRQ_ACK), .IRQ_PEND(b_pend), .INT_OUT(b_int));

   typedef struct {
      logic [DW-1:0] db_a, db_b;
      logic          idle, cont, st_a, st_b, intr;
      logic [NS-1:0] mk_a, mk_b;
      int            cnt_a, cnt_b;
      logic [NI-1:0] pend;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   // reference state
   logic [DW-1:0] m_keep;
   bit            m_st_a, m_st_b;
   logic [NS-1:0] m_mk_a, m_mk_b;
   int            m_cnt_a, m_cnt_b;
   logic [NI-1:0] m_pend;
   logic [NI-1:0] m_hist[$];   // IRQ_IN sampled at the last three edges, newest first
   logic [NS*DW-1:0] data_v;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] slot(int s);
      return DRV_DATA[s*DW +: DW];
   endfunction

   function automatic logic [DW-1:0] lowest_drv();
      for (int s = 0; s < NS; s++) if (DRV_EN[s]) return slot(s);
      return '0;
   endfunction

   function automatic logic [DW-1:0] wired_or();
      logic [DW-1:0] v = '0;
      for (int s = 0; s < NS; s++) if (DRV_EN[s]) v |= slot(s);
      return v;
   endfunction

   task automatic model_status(inout bit st, inout logic [NS-1:0] mk, inout int cnt, input int maxc);
      bit was;
      was = CLR_STATUS ? 1'b0 : st;
      if (CLR_STATUS) begin mk = '0; cnt = 0; end
      if ($countones(DRV_EN) >= 2) begin
         if (!was) mk = DRV_EN;
         st = 1'b1;
         if (cnt < maxc) cnt++;
      end else st = was;
   endtask

   task automatic model_reset();
      m_keep = '0; m_st_a = 0; m_st_b = 0; m_mk_a = '0; m_mk_b = '0;
      m_cnt_a = 0; m_cnt_b = 0; m_pend = '0;
      m_hist.delete();
      repeat (3) m_hist.push_back('0);
   endtask

   task automatic model_edge();
      logic [NI-1:0] rise;
      if (RST) return;
      if (DRV_EN != '0) m_keep = wired_or();
      model_status(m_st_a, m_mk_a, m_cnt_a, 255);
      model_status(m_st_b, m_mk_b, m_cnt_b, 3);
      rise   = m_hist[1] & ~m_hist[2];
      m_pend = (m_pend & ~IRQ_ACK) | rise;
      m_hist.push_front(IRQ_IN);
      void'(m_hist.pop_back());
   endtask

   task automatic push_exp();
      exp_t e;
      e.idle  = (DRV_EN == '0);
      e.cont  = ($countones(DRV_EN) >= 2);
      e.db_a  = e.idle ? '0 : lowest_drv();
      e.db_b  = e.idle ? m_keep : wired_or();
      e.st_a  = m_st_a;  e.st_b  = m_st_b;
      e.mk_a  = m_mk_a;  e.mk_b  = m_mk_b;
      e.cnt_a = m_cnt_a; e.cnt_b = m_cnt_b;
      e.pend  = m_pend;
      e.intr  = |(m_pend & IRQ_MASK);
      exp_q.push_back(e);
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, required %h", nm, $time, act, req);
      end
   endtask

   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("a_db", 32'(a_db), 32'(e.db_a));
         chk("b_db", 32'(b_db), 32'(e.db_b));
         chk("a_idle", 32'(a_idle), 32'(e.idle));
         chk("b_idle", 32'(b_idle), 32'(e.idle));
         chk("a_cont", 32'(a_cont), 32'(e.cont));
         chk("b_cont", 32'(b_cont), 32'(e.cont));
         chk("a_sticky", 32'(a_st), 32'(e.st_a));
         chk("b_sticky", 32'(b_st), 32'(e.st_b));
         chk("a_mask", 32'(a_mk), 32'(e.mk_a));
         chk("b_mask", 32'(b_mk), 32'(e.mk_b));
         chk("a_cnt", 32'(a_cnt), e.cnt_a);
         chk("b_cnt", 32'(b_cnt), e.cnt_b);
         chk("a_pend", 32'(a_pend), 32'(e.pend));
         chk("b_pend", 32'(b_pend), 32'(e.pend));
         chk("a_int", 32'(a_int), 32'(e.intr));
         chk("b_int", 32'(b_int), 32'(e.intr));
      end
   end

   task automatic tick(input logic [NS-1:0] en, input logic clr,
                       input logic [NI-1:0] irq, input logic [NI-1:0] msk, input logic [NI-1:0] ack);
      @(posedge CLK);
      model_edge();
      #1;
      DRV_EN = en; DRV_DATA = data_v; CLR_STATUS = clr;
      IRQ_IN = irq; IRQ_MASK = msk; IRQ_ACK = ack;
      #1 push_exp();
   endtask

   task automatic async_reset(input logic [NI-1:0] irq);
      @(posedge CLK);
      model_edge();
      #1;
      RST = 1'b1;
      DRV_EN = '0; CLR_STATUS = 1'b0; IRQ_ACK = '0; IRQ_IN = irq;
      model_reset();
      #1 push_exp();
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   initial begin
      logic [NI-1:0] irq_r, msk_r, ack_r;
      logic [NS-1:0] en_r;
      int r;
      RST = 1'b1; DRV_EN = '0; DRV_DATA = '0; CLR_STATUS = 1'b0;
      IRQ_IN = '0; IRQ_MASK = '0; IRQ_ACK = '0; data_v = '0;
      model_reset();
      #1 push_exp();
      #11 RST = 1'b0;

      // single driver then idle (keeper holds on b, zero on a)
      data_v[2*DW +: DW] = 26'h2AAAAAA;
      tick(5'b00100, 0, '0, '0, '0);
      repeat (2) tick('0, 0, '0, '0, '0);
      data_v[0 +: DW] = 26'h1234567;
      tick(5'b00001, 0, '0, '0, '0);
      repeat (3) tick('0, 0, '0, '0, '0);
      // contention capture; later event must not replace mask
      data_v[1*DW +: DW] = 26'h0000F0F;
      data_v[3*DW +: DW] = 26'h3000000;
      repeat (2) tick(5'b01010, 0, '0, '0, '0);
      tick('0, 0, '0, '0, '0);
      tick(5'b10001, 0, '0, '0, '0);
      // saturation on b, then clear coinciding with contention, then plain clear
      data_v[0 +: DW]    = 26'h00000F0;
      data_v[1*DW +: DW] = 26'h000000F;
      repeat (5) tick(5'b00011, 0, '0, '0, '0);
      tick(5'b00011, 1, '0, '0, '0);
      tick('0, 1, '0, '0, '0);
      tick('0, 0, '0, '0, '0);
      // level-held irq 2: pends once, ack clears, no re-set while high
      repeat (4) tick('0, 0, 4'b0100, 4'b0100, '0);
      tick('0, 0, 4'b0100, 4'b0100, 4'b0100);
      repeat (4) tick('0, 0, 4'b0100, 4'b0100, '0);
      tick('0, 0, '0, 4'b0100, '0);
      // masked irq 0 still pends; unmask raises INT_OUT; ack coinciding with a new rise
      repeat (4) tick('0, 0, 4'b0001, '0, '0);
      tick('0, 0, 4'b0001, 4'b0001, '0);
      repeat (2) tick('0, 0, '0, 4'b0001, '0);
      tick('0, 0, 4'b0001, 4'b0001, '0);
      tick('0, 0, 4'b0001, 4'b0001, '0);
      tick('0, 0, 4'b0001, 4'b0001, 4'b0001);
      repeat (2) tick('0, 0, 4'b0001, 4'b0001, '0);

      irq_r = 4'b0001; msk_r = 4'b0001;
      for (int n = 0; n < 400; n++) begin
         if (n == 200) begin
            irq_r = '1;
            async_reset(irq_r);
         end
         r = $urandom_range(0, 9);
         if (r < 3)      en_r = '0;
         else if (r < 6) en_r = NS'(1) << $urandom_range(0, NS-1);
         else            en_r = NS'($urandom);
         for (int s = 0; s < NS; s++) data_v[s*DW +: DW] = DW'($urandom);
         for (int c = 0; c < NI; c++) if ($urandom_range(0, 5) == 0) irq_r[c] = ~irq_r[c];
         if ($urandom_range(0, 7) == 0) msk_r = NI'($urandom);
         ack_r = ($urandom_range(0, 3) == 0) ? NI'($urandom) : '0;
         tick(en_r, ($urandom_range(0, 9) == 0), irq_r, msk_r, ack_r);
      end

      @(posedge CLK);
      @(negedge CLK);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/backplane_bus_fabric.md
Name: backplane_bus_fabric

Overview:
- Parametrised replacement for the tri-state card backplane: slot drivers feed an explicit resolver instead of a wired tri0 bus.
- Adds a selectable bus-keeper, contention detection and capture, and a synchronised, latched multi-channel interrupt front end.
- Sits at top level between the cards (ALU, Registers, Memory, Control, IO) and the shared data bus, and between external IRQ pins and Control's interrupt input.

Parameters:
- DW, 26, data bus width in bits.
- NSLOTS, 5, number of card slots that can drive the bus.
- RESOLVE, 1, contention resolution: 0 = wired-OR of all enabled drivers; 1 = lowest enabled slot index wins.
- KEEPER, 0, idle bus value: 0 = bus reads 0 (tri0 behaviour); 1 = bus holds the last driven value.
- CW, 8, width of the saturating contention counter.
- NIRQ, 4, number of external interrupt channels.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- DRV_EN  in  NSLOTS  per-slot drive enable.
- DRV_DATA  in  NSLOTS*DW  per-slot drive data; slot i occupies bits [i*DW +: DW].
- DB  out  DW  resolved bus value, combinational.
- BUS_IDLE  out  1  high when no DRV_EN bit is set, combinational.
- CONTENTION  out  1  high when two or more DRV_EN bits are set, combinational.
- CONT_STICKY  out  1  registered contention status flag.
- CONT_MASK  out  NSLOTS  DRV_EN value captured at the first contention after a clear.
- CONT_CNT  out  CW  saturating count of contention cycles.
- CLR_STATUS  in  1  synchronous clear of CONT_STICKY, CONT_MASK and CONT_CNT.
- IRQ_IN  in  NIRQ  asynchronous interrupt request lines.
- IRQ_MASK  in  NIRQ  per-channel enable; 1 = enabled.
- IRQ_ACK  in  NIRQ  per-channel pending clear, single-cycle pulse.
- IRQ_PEND  out  NIRQ  latched pending bits.
- INT_OUT  out  1  OR of (IRQ_PEND & IRQ_MASK), drives Control's INT_IN.

Behaviour:
- Reset values: keeper register = 0, CONT_STICKY = 0, CONT_MASK = 0, CONT_CNT = 0, synchroniser flops = 0, IRQ_PEND = 0, INT_OUT = 0.
- DB while in reset is the pure combinational resolve using keeper = 0.
- Resolver, single driver: DB = that slot's data, zero latency.
- Resolver, multiple drivers: with RESOLVE=0, DB = bitwise OR of all enabled slots' data; with RESOLVE=1, DB = data of the lowest enabled index.
- Resolver, no drivers: DB = 0 if KEEPER=0, otherwise DB = the keeper register.
- Keeper register loads DB on every clock edge where BUS_IDLE=0; it holds otherwise. It exists only when KEEPER=1; with KEEPER=0 it is tied to 0.
- Contention status, on each edge where CONTENTION=1:
  - CONT_STICKY is set.
  - CONT_MASK loads DRV_EN only if CONT_STICKY was 0 before that edge (first event is preserved).
  - CONT_CNT increments and saturates at 2^CW-1 with no wrap.
- CLR_STATUS=1 clears all three contention outputs on the next edge. If CONTENTION=1 on that same edge, the set wins: CONT_STICKY=1, CONT_MASK=current DRV_EN, CONT_CNT=1.
- IRQ path per channel: two-flop synchroniser (s1, s2), then an edge-detect flop s3. A rising edge is s2=1 and s3=0.
  - IRQ_IN high first sampled at edge k: s1 at k, s2 at k+1, IRQ_PEND set at edge k+2.
  - Pulses shorter than one clock period may be lost; this is allowed.
  - Level-held input sets IRQ_PEND only once. After an IRQ_ACK, the channel needs a falling then rising edge to re-arm.
  - IRQ_ACK[i]=1 clears IRQ_PEND[i] at the next edge. A rising edge coinciding with an ACK on the same edge leaves IRQ_PEND=1 (set wins).
  - Masked channels still latch IRQ_PEND. INT_OUT reflects the mask combinationally, so unmasking a pending channel raises INT_OUT in the same cycle.
- Reset asserted mid-operation clears all state immediately (asynchronous). Synchroniser flops restart at 0, so an IRQ_IN already high at deassertion produces one edge, i.e. IRQ_PEND two edges later.

Test Plan:
- DW=26, KEEPER=0: slot 2 drives 0x2AAAAAA for one cycle, then idle → DB=0x2AAAAAA then 0x0000000; BUS_IDLE goes 0→1; CONT_CNT stays 0.
- KEEPER=1: slot 0 drives 0x1234567 for one cycle, then 3 idle cycles → DB holds 0x1234567 for all idle cycles. Assert RST → DB=0 asynchronously.
- RESOLVE=1: slots 1 and 3 drive 0x0000F0F and 0x3000000 for 2 cycles → DB=0x0000F0F, CONTENTION=1, CONT_STICKY=1, CONT_MASK=5'b01010, CONT_CNT=2. A later contention of slots 0 and 4 leaves CONT_MASK=5'b01010.
- RESOLVE=0, CW=2: slots 0 and 1 drive 0x0F0 and 0x00F for 5 cycles → DB=0x0FF, CONT_CNT saturates at 3. CLR_STATUS together with contention on the same edge → CONT_STICKY=1, CONT_CNT=1.
- IRQ_IN[2] rises and is held high, IRQ_MASK=4'b0100 → IRQ_PEND[2]=1 and INT_OUT=1 two edges after first sample. Then IRQ_ACK[2] → IRQ_PEND=0, and no re-set while IRQ_IN stays high.
- IRQ_IN[0] rise with IRQ_MASK=0 → IRQ_PEND[0]=1, INT_OUT=0. Setting IRQ_MASK[0]=1 → INT_OUT=1 in the same cycle. ACK coinciding with a new rising edge → IRQ_PEND[0] remains 1.
